// File: rtl/reg_scoreboard_pkg.sv
// Shared register-number types and constants for the write scoreboard.
// Covers the 16 architectural registers r0-r15.
package reg_scoreboard_pkg;

  localparam int NUM_REGS = 16;

  typedef logic [3:0] regnum_t;

  localparam regnum_t REG_PC = 4'd15;
  localparam regnum_t REG_LR = 4'd14;

endpackage

// File: rtl/reg_scoreboard_decoder.sv
// 4-to-16 one-hot decoder with enable.
// The output is all zeros whenever en is low.
module decoder_4_to_16
  import reg_scoreboard_pkg::*;
(
  input  logic                en,
  input  regnum_t             sel,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Write scoreboard for r0-r15: per-register pending-write counters plus
// read-after-write hazard flags for three source operands.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter bit TRACK_PC = 1'b1
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_valid,
  input  regnum_t             issue_rd,
  output logic                issue_ok,
  input  logic                wb_valid,
  input  regnum_t             wb_rd,
  input  regnum_t             rs_a,
  input  regnum_t             rs_b,
  input  regnum_t             rs_c,
  output logic                hazard_a,
  output logic                hazard_b,
  output logic                hazard_c,
  output logic [NUM_REGS-1:0] pending,
  output logic                busy,
  output logic                err_underflow
);

  localparam int CW = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PEND);
  // With the PC untracked, bit 15 is removed from both masks so r15 never counts.
  localparam logic [NUM_REGS-1:0] TRACK_MASK =
    TRACK_PC ? {NUM_REGS{1'b1}} : ~(NUM_REGS'(1) << REG_PC);

  logic [NUM_REGS-1:0][CW-1:0] count;
  logic [NUM_REGS-1:0]         issue_dec;
  logic [NUM_REGS-1:0]         wb_dec;
  logic [NUM_REGS-1:0]         issue_mask;
  logic [NUM_REGS-1:0]         wb_mask;
  logic [NUM_REGS-1:0]         pend_next;
  logic [NUM_REGS-1:0]         uf_hit;
  logic                        pc_untracked;
  logic                        same_reg_wb;
  logic                        issue_en;

  assign pc_untracked = (TRACK_PC == 1'b0) && (issue_rd == REG_PC);
  assign same_reg_wb  = wb_valid && (wb_rd == issue_rd);
  assign issue_ok     = pc_untracked || (count[issue_rd] != MAX_CNT) || same_reg_wb;
  assign issue_en     = issue_valid && issue_ok;

  decoder_4_to_16 u_issue_dec (
    .en     (issue_en),
    .sel    (issue_rd),
    .onehot (issue_dec)
  );

  decoder_4_to_16 u_wb_dec (
    .en     (wb_valid),
    .sel    (wb_rd),
    .onehot (wb_dec)
  );

  assign issue_mask = issue_dec & TRACK_MASK;
  assign wb_mask    = wb_dec & TRACK_MASK;

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          uf;

    always_comb begin
      cnt_d = cnt_q;
      uf    = 1'b0;
      unique case ({issue_mask[n], wb_mask[n]})
        2'b10: cnt_d = cnt_q + CW'(1);
        2'b01: begin
          if (cnt_q == '0) uf = 1'b1;
          else             cnt_d = cnt_q - CW'(1);
        end
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset)      cnt_q <= '0;
      else if (flush) cnt_q <= '0;
      else            cnt_q <= cnt_d;
    end

    assign count[n]     = cnt_q;
    assign pend_next[n] = (cnt_d != '0);
    assign uf_hit[n]    = uf;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pending <= '0;
      busy    <= 1'b0;
    end else begin
      pending <= pend_next;
      busy    <= |pend_next;
    end
  end

  // Sticky until reset; a flush cycle ignores the writeback entirely.
  always_ff @(posedge clk) begin
    if (reset)                    err_underflow <= 1'b0;
    else if (!flush && |uf_hit)   err_underflow <= 1'b1;
  end

  assign hazard_a = pending[rs_a];
  assign hazard_b = pending[rs_b];
  assign hazard_c = pending[rs_c];

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: two DUTs (PC tracked / untracked) share stimulus; a
// count-based reference model predicts outputs, a monitor pops and compares.
module tb_reg_scoreboard;

  localparam int MAX_PEND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, flush, issue_valid, wb_valid;
  logic [3:0] issue_rd, wb_rd, rs_a, rs_b, rs_c;

  logic        ok0, ha0, hb0, hc0, busy0, err0;
  logic        ok1, ha1, hb1, hc1, busy1, err1;
  logic [15:0] pend0, pend1;

  reg_scoreboard #(.MAX_PEND(MAX_PEND), .TRACK_PC(1'b1)) dut_pc (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(ok0),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .rs_a(rs_a), .rs_b(rs_b), .rs_c(rs_c),
    .hazard_a(ha0), .hazard_b(hb0), .hazard_c(hc0),
    .pending(pend0), .busy(busy0), .err_underflow(err0)
  );

  reg_scoreboard #(.MAX_PEND(MAX_PEND), .TRACK_PC(1'b0)) dut_nopc (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(ok1),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .rs_a(rs_a), .rs_b(rs_b), .rs_c(rs_c),
    .hazard_a(ha1), .hazard_b(hb1), .hazard_c(hc1),
    .pending(pend1), .busy(busy1), .err_underflow(err1)
  );

  typedef struct packed {
    logic [1:0]       ok;
    logic [1:0]       ha;
    logic [1:0]       hb;
    logic [1:0]       hc;
    logic [1:0]       busy;
    logic [1:0]       err;
    logic [1:0][15:0] pend;
    int               cyc;
  } exp_t;

  exp_t q[$];

  // Reference model: d=0 tracks the PC, d=1 does not.
  int cnt [2][16];
  bit err_m [2];

  int total = 0;
  int passed = 0;
  int cyc = 0;
  bit done = 1'b0;

  function automatic bit untracked(int d, logic [3:0] r);
    return (d == 1) && (r == 4'd15);
  endfunction

  function automatic bit model_ok(int d);
    return untracked(d, issue_rd) || (cnt[d][issue_rd] < MAX_PEND) ||
           (wb_valid && wb_rd == issue_rd);
  endfunction

  function automatic logic [15:0] model_pend(int d);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = (cnt[d][i] != 0);
    return p;
  endfunction

  task automatic chk(string name, int d, int c, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, c, act, exp);
  endtask

  task automatic step(input bit iv, input logic [3:0] ird, input bit wv,
                      input logic [3:0] wrd, input bit fl, input logic [3:0] ra,
                      input bit rst);
    exp_t e;
    bit   okm [2];
    @(negedge clk);
    issue_valid = iv; issue_rd = ird;
    wb_valid = wv;    wb_rd = wrd;
    flush = fl;       reset = rst;
    rs_a = ra;
    rs_b = 4'($urandom_range(0, 15));
    rs_c = 4'($urandom_range(0, 15));
    #1;
    cyc++;
    e = '0;
    e.cyc = cyc;
    for (int d = 0; d < 2; d++) begin
      okm[d]    = model_ok(d);
      e.ok[d]   = okm[d];
      e.ha[d]   = cnt[d][rs_a] != 0;
      e.hb[d]   = cnt[d][rs_b] != 0;
      e.hc[d]   = cnt[d][rs_c] != 0;
      e.pend[d] = model_pend(d);
      e.busy[d] = |model_pend(d);
      e.err[d]  = err_m[d];
    end
    q.push_back(e);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) cnt[d][i] = 0;
        err_m[d] = 1'b0;
      end else if (fl) begin
        for (int i = 0; i < 16; i++) cnt[d][i] = 0;
      end else begin
        if (iv && okm[d] && !untracked(d, ird)) cnt[d][ird]++;
        if (wv && !untracked(d, wrd)) begin
          if (cnt[d][wrd] == 0) err_m[d] = 1'b1;
          else cnt[d][wrd]--;
        end
      end
    end
  endtask

  task automatic idle(input logic [3:0] ra);
    step(0, 4'd0, 0, 4'd0, 0, ra, 0);
  endtask

  function automatic logic [3:0] pick_reg();
    logic [3:0] r;
    case ($urandom_range(0, 3))
      0: r = 4'd5;
      1: r = 4'd15;
      default: r = 4'($urandom_range(0, 15));
    endcase
    return r;
  endfunction

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) cnt[d][i] = 0;
      err_m[d] = 1'b0;
    end
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0;
    issue_rd = '0; wb_rd = '0; rs_a = '0; rs_b = '0; rs_c = '0;
    repeat (2) @(negedge clk);

    idle(4'd3);
    // single issue/writeback with hazard on rs_a
    step(1, 4'd3, 0, 4'd0, 0, 4'd3, 0);
    step(0, 4'd0, 1, 4'd3, 0, 4'd3, 0);
    idle(4'd3);
    idle(4'd3);
    // saturation at MAX_PEND on r5
    repeat (3) step(1, 4'd5, 0, 4'd0, 0, 4'd5, 0);
    step(1, 4'd5, 0, 4'd0, 0, 4'd5, 0);
    step(1, 4'd5, 1, 4'd5, 0, 4'd5, 0);
    repeat (3) step(0, 4'd0, 1, 4'd5, 0, 4'd5, 0);
    idle(4'd5);
    // issue and writeback of different registers in one cycle
    step(1, 4'd2, 0, 4'd0, 0, 4'd2, 0);
    step(1, 4'd7, 1, 4'd2, 0, 4'd7, 0);
    step(0, 4'd0, 1, 4'd7, 0, 4'd7, 0);
    idle(4'd7);
    // underflow, sticky across flush, cleared by reset
    step(0, 4'd0, 1, 4'd9, 0, 4'd9, 0);
    idle(4'd9);
    step(0, 4'd0, 0, 4'd0, 1, 4'd9, 0);
    idle(4'd9);
    step(0, 4'd0, 0, 4'd0, 0, 4'd9, 1);
    idle(4'd9);
    // flush with concurrent issue
    step(1, 4'd1, 0, 4'd0, 0, 4'd1, 0);
    step(1, 4'd4, 0, 4'd0, 0, 4'd4, 0);
    step(1, 4'd14, 0, 4'd0, 0, 4'd14, 0);
    step(1, 4'd6, 0, 4'd0, 1, 4'd6, 0);
    idle(4'd6);
    // r15 handling in both configurations
    step(1, 4'd15, 0, 4'd0, 0, 4'd15, 0);
    idle(4'd15);
    step(0, 4'd0, 1, 4'd15, 0, 4'd15, 0);
    idle(4'd15);
    step(0, 4'd0, 1, 4'd15, 0, 4'd15, 0);
    idle(4'd15);
    step(0, 4'd0, 0, 4'd0, 0, 4'd0, 1);

    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 3) != 0, pick_reg(), $urandom_range(0, 2) == 0,
           pick_reg(), $urandom_range(0, 49) == 0, pick_reg(),
           $urandom_range(0, 199) == 0);
    end
    idle(4'd0);
    done = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    int   budget;
    logic [1:0]       a_ok, a_ha, a_hb, a_hc, a_busy, a_err;
    logic [1:0][15:0] a_pend;
    budget = 0;
    while (!(done && q.size() == 0)) begin
      @(negedge clk);
      #2;
      budget++;
      if (budget > 5000) begin
        total++;
        $display("FAIL timeout: monitor budget %0d expected drain before 5000", budget);
        break;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        a_ok = {ok1, ok0};     a_ha = {ha1, ha0};
        a_hb = {hb1, hb0};     a_hc = {hc1, hc0};
        a_busy = {busy1, busy0}; a_err = {err1, err0};
        a_pend = {pend1, pend0};
        for (int d = 0; d < 2; d++) begin
          chk("issue_ok", d, e.cyc, 16'(a_ok[d]), 16'(e.ok[d]));
          chk("hazard_a", d, e.cyc, 16'(a_ha[d]), 16'(e.ha[d]));
          chk("hazard_b", d, e.cyc, 16'(a_hb[d]), 16'(e.hb[d]));
          chk("hazard_c", d, e.cyc, 16'(a_hc[d]), 16'(e.hc[d]));
          chk("pending", d, e.cyc, a_pend[d], e.pend[d]);
          chk("busy", d, e.cyc, 16'(a_busy[d]), 16'(e.busy[d]));
          chk("err_underflow", d, e.cyc, 16'(a_err[d]), 16'(e.err[d]));
        end
      end
    end
  endtask

  initial begin
    fork
      drive();
      monitor();
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-file write scoreboard for the ARMv4 core pipeline. Tracks outstanding writes to the 16 architectural registers r0-r15.
- On issue, decodes the 4-bit destination number to a one-hot mask and increments that register's pending count. Writeback decrements the count.
- Flags read-after-write hazards on up to three source operands, so the issue stage can stall.
- Sits between decode/issue and the register-file writeback port.

Parameters:
- MAX_PEND, 3, maximum outstanding writes per register; counter width is clog2(MAX_PEND+1).
- TRACK_PC, 1, when 0 the scoreboard never marks r15 as pending (PC writes are handled by the branch unit).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; clears all pending counts
- issue_valid  in  1  instruction with a destination register is issuing this cycle
- issue_rd  in  4  destination register number
- issue_ok  out  1  combinational; issue accepted this cycle
- wb_valid  in  1  writeback occurs this cycle
- wb_rd  in  4  writeback register number
- rs_a  in  4  source operand A register number
- rs_b  in  4  source operand B register number
- rs_c  in  4  source operand C register number (shift amount / store data)
- hazard_a  out  1  combinational; pending[rs_a]
- hazard_b  out  1  combinational; pending[rs_b]
- hazard_c  out  1  combinational; pending[rs_c]
- pending  out  16  registered; bit n = (count[n] != 0)
- busy  out  1  registered; any pending bit set
- err_underflow  out  1  sticky; writeback seen to a register with count 0

Behaviour:
- Reset (synchronous, highest priority): all counts 0, pending=16'h0000, busy=0, err_underflow=0.
- Flush (next priority): all counts cleared to 0 at the clock edge. Issue and writeback in the same cycle are ignored. err_underflow is not cleared by flush.
- Otherwise, counts update at the edge as follows.
- Issue and writeback masks: issue_mask = onehot(issue_rd) gated by issue_valid&issue_ok; wb_mask = onehot(wb_rd) gated by wb_valid.
- Per register n:
  - issue only: count+1
  - wb only: count-1
  - both same register: count unchanged
  - neither: unchanged
- issue_ok = !(count[issue_rd]==MAX_PEND), with one exception. If a writeback to the same register occurs in the same cycle, issue_ok=1 even at MAX_PEND, because the net count is unchanged.
- Issue rejection: with issue_ok=0 the issue is dropped and no count changes. The issue stage must hold the instruction and retry.
- TRACK_PC=0 with issue_rd=15: issue_ok=1, count[15] is never incremented, and a writeback to r15 does not set err_underflow.
- Underflow: writeback to a register with count 0 (and no same-cycle issue to it) leaves the count at 0. err_underflow is set at the next edge and holds until reset.
- Hazard outputs use registered state only. A same-cycle writeback does not clear a hazard until the next cycle; the register file handles bypass elsewhere.
- A same-cycle issue is not visible on the hazard outputs until the next cycle.
- Latency: pending and busy reflect an issue or writeback one cycle after the event.
- No wrap-around: counts saturate logically via the issue_ok gating. A count can never exceed MAX_PEND or go below 0.
- Reset asserted mid-stream discards all state, regardless of flush, issue or writeback.

Decomposition:
- Shared package contents: NUM_REGS=16, REG_PC=4'd15, REG_LR=4'd14, regnum_t (4-bit).
- Sub-module decoder_4_to_16: combinational, en + 4-bit in -> 16-bit one-hot out, all-zero when en=0. Instantiated twice (issue and writeback).
- Per-register counter logic is a generate loop inside reg_scoreboard; no further sub-modules.

Test Plan:
- Reset then issue r3 -> next cycle pending=16'h0008, busy=1. With rs_a=3, hazard_a=1. Writeback r3 -> next cycle pending=16'h0000, busy=0.
- Three issues to r5 (MAX_PEND=3) -> fourth issue to r5 has issue_ok=0 and count stays 3. Same fourth issue with simultaneous wb r5 -> issue_ok=1 and count stays 3.
- Issue r7 and writeback r2 in the same cycle (r2 pending=1) -> pending goes from 16'h0004 to 16'h0080.
- Writeback r9 with count 0 -> err_underflow=1 next cycle, pending unchanged. err_underflow survives a flush and clears only on reset.
- Pending r1, r4, r14, then flush together with issue r6 -> next cycle pending=16'h0000 and the issue is ignored.
- TRACK_PC=0: issue r15 -> issue_ok=1, pending[15] stays 0. Then wb r15 -> err_underflow stays 0.
